// File: rtl/otter_intc.sv
// Memory-mapped interrupt controller for otter_mcu: syncs sources, detects level/edge
// events with polarity select, latches them in PENDING and drives a masked, registered vector.
module otter_intc #(
  parameter int unsigned N_SRC     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h1100_0000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SRC-1:0] i_src,
  input  logic             i_re,
  input  logic             i_we,
  input  logic [3:0]       i_sel,
  input  logic [31:0]      i_addr,
  input  logic [31:0]      i_w_data,
  output logic [31:0]      o_r_data,
  output logic [31:0]      o_intrpt
);

  localparam int unsigned W = N_SRC;

  localparam logic [3:0] IDX_PENDING  = 4'h0;
  localparam logic [3:0] IDX_ENABLE   = 4'h1;
  localparam logic [3:0] IDX_MODE     = 4'h2;
  localparam logic [3:0] IDX_POLARITY = 4'h3;
  localparam logic [3:0] IDX_RAW      = 4'h4;
  localparam logic [3:0] IDX_SET      = 4'h5;

  logic [W-1:0] sync1, sync2, prev;
  logic [W-1:0] pending, enable, mode, polarity;
  logic [W-1:0] adj, edge_evt, w1c, w1s, pending_nxt;
  logic [W-1:0] wr_bits, wr_mask;
  logic [31:0]  lane_mask, wr_bits_32, rd_val;
  logic [3:0]   idx;
  logic         hit, wr, rd;
  logic         unused_bits;

  assign hit        = (i_addr[31:6] == BASE_ADDR[31:6]);
  assign idx        = i_addr[5:2];
  assign wr         = i_we & hit;
  assign rd         = i_re & hit;
  assign lane_mask  = {{8{i_sel[3]}}, {8{i_sel[2]}}, {8{i_sel[1]}}, {8{i_sel[0]}}};
  assign wr_bits_32 = i_w_data & lane_mask;
  assign wr_bits    = wr_bits_32[W-1:0];
  assign wr_mask    = lane_mask[W-1:0];
  assign unused_bits = ^{i_addr[1:0], wr_bits_32, lane_mask};

  assign adj      = sync2 ^ polarity;
  assign edge_evt = adj & ~prev;
  assign w1c      = (wr && idx == IDX_PENDING) ? wr_bits : '0;
  assign w1s      = (wr && idx == IDX_SET)     ? wr_bits : '0;

  // Level bits track adj; edge bits: event and SET win over W1C.
  assign pending_nxt = (~mode & adj) | (mode & ((pending & ~w1c) | edge_evt | w1s));

  // Read mux samples pre-write register state.
  always_comb begin
    rd_val = '0;
    case (idx)
      IDX_PENDING:  rd_val = 32'(pending);
      IDX_ENABLE:   rd_val = 32'(enable);
      IDX_MODE:     rd_val = 32'(mode);
      IDX_POLARITY: rd_val = 32'(polarity);
      IDX_RAW:      rd_val = 32'(adj);
      default:      rd_val = '0;
    endcase
  end

  // Source synchroniser and edge history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= i_src;
      sync2 <= sync1;
      prev  <= adj;
    end
  end

  // Configuration and pending registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending  <= '0;
      enable   <= '0;
      mode     <= '0;
      polarity <= '0;
    end else begin
      pending <= pending_nxt;
      if (wr && idx == IDX_ENABLE)   enable   <= (enable   & ~wr_mask) | wr_bits;
      if (wr && idx == IDX_MODE)     mode     <= (mode     & ~wr_mask) | wr_bits;
      if (wr && idx == IDX_POLARITY) polarity <= (polarity & ~wr_mask) | wr_bits;
    end
  end

  // Registered bus read data (zero when not addressed) and interrupt vector.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_r_data <= '0;
      o_intrpt <= '0;
    end else begin
      o_r_data <= rd ? rd_val : 32'h0;
      o_intrpt <= 32'(pending & enable);
    end
  end

endmodule

// File: tb/tb_otter_intc.sv
// Directed self-checking bench for otter_intc with hand-computed expectations.
module tb_otter_intc;

  localparam logic [31:0] BASE = 32'h1100_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src;
  logic        re, we;
  logic [3:0]  sel;
  logic [31:0] addr, wdata;
  logic [31:0] r_data, intrpt;

  int checks = 0;
  int errors = 0;

  otter_intc #(.N_SRC(32), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_rst(rst), .i_src(src), .i_re(re), .i_we(we), .i_sel(sel),
    .i_addr(addr), .i_w_data(wdata), .o_r_data(r_data), .o_intrpt(intrpt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one bus cycle from a negedge; returns at the next negedge with o_r_data valid.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    re = r; we = w; addr = a; wdata = d; sel = s;
    @(negedge clk);
    re = 1'b0; we = 1'b0; sel = 4'h0; wdata = 32'h0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    access(1'b0, 1'b1, BASE + 32'(off), d, s);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    access(1'b1, 1'b0, a, 32'h0, 4'h0);
    check(tag, r_data, exp);
  endtask

  initial begin
    rst = 1'b1; src = 32'hFFFF_FFFF; re = 1'b0; we = 1'b0;
    sel = 4'h0; addr = 32'h0; wdata = 32'h0;

    // Reset with all sources high
    tick(2);
    check("rst_intrpt_a", intrpt, 32'h0);
    check("rst_rdata_a", r_data, 32'h0);
    tick(2);
    check("rst_intrpt_b", intrpt, 32'h0);
    check("rst_rdata_b", r_data, 32'h0);
    rst = 1'b0;
    tick(5);
    check("en0_intrpt", intrpt, 32'h0);
    rd_check("level_all_pend", BASE + 32'h00, 32'hFFFF_FFFF);
    src = 32'h0;
    tick(4);

    // Edge pulse on bit 0
    wr(8'h04, 32'h1, 4'hF);
    wr(8'h08, 32'h1, 4'hF);
    src[0] = 1'b1;
    tick(1);
    src[0] = 1'b0;
    tick(2);
    check("edge0_e2", intrpt, 32'h0);
    tick(1);
    check("edge0_e3", intrpt, 32'h1);
    rd_check("edge0_pend", BASE + 32'h00, 32'h1);
    wr(8'h00, 32'h1, 4'hF);
    check("w1c0_edge1", intrpt, 32'h1);
    tick(1);
    check("w1c0_edge2", intrpt, 32'h0);

    // Level mode, active-low bit 5
    wr(8'h04, 32'h21, 4'hF);
    wr(8'h0C, 32'h20, 4'hF);
    tick(4);
    check("lvl5_on", intrpt, 32'h20);
    wr(8'h00, 32'h20, 4'hF);
    rd_check("lvl5_w1c_pend", BASE + 32'h00, 32'h20);
    src[5] = 1'b1;
    tick(3);
    check("lvl5_off_e2", intrpt, 32'h20);
    tick(1);
    check("lvl5_off_e3", intrpt, 32'h0);

    // Edge event on bit 2 in the same cycle as its W1C
    wr(8'h08, 32'h5, 4'hF);
    wr(8'h04, 32'h4, 4'hF);
    src[2] = 1'b1;
    tick(1);
    src[2] = 1'b0;
    tick(1);
    wr(8'h00, 32'h4, 4'hF);
    rd_check("evt_vs_w1c", BASE + 32'h00, 32'h4);
    check("evt_vs_w1c_int", intrpt, 32'h4);
    wr(8'h00, 32'h4, 4'hF);
    tick(1);
    rd_check("w1c2_pend", BASE + 32'h00, 32'h0);

    // Byte-lane write and read-during-write
    wr(8'h04, 32'h0, 4'hF);
    wr(8'h04, 32'hFFFF_FFFF, 4'b0010);
    rd_check("lane_enable", BASE + 32'h04, 32'h0000_FF00);
    access(1'b1, 1'b1, BASE + 32'h04, 32'h0, 4'hF);
    check("rdw_prewrite", r_data, 32'h0000_FF00);
    rd_check("rdw_after", BASE + 32'h04, 32'h0);
    wr(8'h04, 32'h0000_FF00, 4'hF);

    // Reserved and non-hit reads, RAW, MODE
    wr(8'h20, 32'hFFFF_FFFF, 4'hF);
    rd_check("rsvd_20", BASE + 32'h20, 32'h0);
    rd_check("nohit", 32'h1200_0004, 32'h0);
    tick(1);
    check("nohit_idle", r_data, 32'h0);
    src[7] = 1'b1;
    tick(3);
    rd_check("raw_bit7", BASE + 32'h10, 32'h80);
    src[7] = 1'b0;
    tick(4);
    rd_check("raw_pol5", BASE + 32'h10, 32'h0);
    rd_check("mode_rd", BASE + 32'h08, 32'h5);

    // SET into edge bit 3; level bit 4 unaffected
    wr(8'h08, 32'hD, 4'hF);
    wr(8'h14, 32'h18, 4'hF);
    rd_check("set_pend", BASE + 32'h00, 32'h8);
    wr(8'h04, 32'h8, 4'hF);
    tick(1);
    check("set_intrpt", intrpt, 32'h8);

    // Reset mid-pending with a read in flight
    rst = 1'b1; re = 1'b1; addr = BASE;
    tick(1);
    check("midrst_intrpt", intrpt, 32'h0);
    check("midrst_rdata", r_data, 32'h0);
    rst = 1'b0; re = 1'b0;
    rd_check("midrst_pend", BASE + 32'h00, 32'h0);
    rd_check("midrst_en", BASE + 32'h04, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/otter_intc.md
Name: otter_intc

Overview:
- Memory-mapped interrupt controller that drives the 32-bit interrupt vector input of otter_mcu.
- Synchronises up to 32 asynchronous interrupt sources and detects level or edge events per source, with polarity select.
- Latches events in a pending register, masks them with an enable register and presents the result on a registered output vector.
- Configured and serviced over the MCU data-memory bus: re/we/sel/addr/w_data in, r_data out.

Parameters:
- N_SRC, 32, number of implemented sources (1..32). Bits at or above N_SRC read 0 and ignore writes.
- BASE_ADDR, 32'h1100_0000, register block base address. Must be 64-byte aligned.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_src  in  N_SRC  raw interrupt sources, asynchronous to i_clk.
- i_re  in  1  bus read strobe.
- i_we  in  1  bus write strobe.
- i_sel  in  4  write byte-lane enables; bit n enables w_data[8n+7:8n].
- i_addr  in  32  bus byte address.
- i_w_data  in  32  bus write data.
- o_r_data  out  32  bus read data, one-cycle latency.
- o_intrpt  out  32  interrupt vector to MCU; bits at or above N_SRC are tied 0.

Behaviour:
- Reset (i_rst high at a rising edge): clears sync flops, prev flops, PENDING, ENABLE, MODE, POLARITY, o_r_data and o_intrpt to 0. Reset mid-operation discards any in-flight edge or read.
- Address hit: i_addr[31:6] == BASE_ADDR[31:6]. Register index is i_addr[5:2]; i_addr[1:0] is ignored.
- Register map (offset, access, meaning):
  - 0x00 PENDING: R / W1C.
  - 0x04 ENABLE: RW.
  - 0x08 MODE: RW; 1 = edge, 0 = level.
  - 0x0C POLARITY: RW; 1 = active-low / falling edge.
  - 0x10 RAW: R; polarity-adjusted synced input.
  - 0x14 SET: W1S into PENDING; affects edge-mode bits only.
  - 0x18..0x3C: read 0, writes ignored.
- Writes:
  - Take effect at the rising edge where i_we is high and the address hits.
  - Only lanes with i_sel set are affected.
  - For W1C and W1S, a byte lane with i_sel clear acts as all-zero.
- Reads:
  - If i_re is high and the address hits in cycle N, o_r_data holds the register value sampled at the end of cycle N from cycle N+1 onward.
  - Otherwise o_r_data is 0 in the next cycle, so it can be OR-muxed onto the bus.
  - Simultaneous i_re and i_we to the same register returns the pre-write value.
- Synchronisation: two flops per source, sync1 then sync2. The adjusted value is adj = sync2 XOR POLARITY. A prev flop holds the previous adj.
- Level mode (MODE bit 0):
  - PENDING bit is loaded with adj every cycle.
  - W1C and SET have no lasting effect on that bit.
- Edge mode (MODE bit 1):
  - An event occurs when adj = 1 and prev = 0.
  - An event sets the PENDING bit; W1C clears it.
  - Event and W1C in the same cycle: the set wins and the bit stays 1.
  - SET and W1C on the same bit cannot occur, since they are different addresses.
- Changing MODE or POLARITY can create a spurious edge on the next cycle. This is permitted; software clears PENDING afterwards.
- o_intrpt is registered: o_intrpt <= PENDING & ENABLE, using the PENDING value before the current edge's update.
- Latency: let E0 be the edge at which i_src is first sampled asserted.
  - sync2 valid after E1.
  - PENDING set after E2.
  - o_intrpt asserted after E3, i.e. 3 cycles after E0.
  - Deassertion in level mode follows the same 3-cycle path.
  - W1C in cycle N drops o_intrpt after edge N+1.

Test Plan:
- Reset with all i_src = 1 → o_intrpt = 0 and o_r_data = 0 throughout reset. After release, with ENABLE = 0, o_intrpt stays 0.
- Write ENABLE = 0x1, MODE = 0x1 (sel 4'hF); pulse i_src[0] high for 1 cycle at E0 → PENDING reads 0x1 and o_intrpt[0] = 1 from E0+3. Write PENDING = 0x1 → o_intrpt = 0 two edges later.
- Level mode, POLARITY[5] = 1, ENABLE[5] = 1; drive i_src[5] = 0 → o_intrpt[5] = 1. W1C PENDING = 0x20 while the source is still low → PENDING[5] reads 1 again. Set i_src[5] = 1 → o_intrpt[5] = 0 after 3 cycles.
- Edge event on bit 2 arriving in the same cycle as W1C of bit 2 → PENDING[2] remains 1.
- Write ENABLE = 0xFFFF_FFFF with i_sel = 4'b0010 → ENABLE reads 0x0000_FF00.
- Read offset 0x20 → 0. Read to a non-hit address → o_r_data = 0. SET write of 0x8 with MODE[3] = 1 → PENDING = 0x8. Assert i_rst mid-pending → all outputs 0 on the next cycle.
